// File: rtl/ram_pkg.sv
// Shared constants and the clear-sequencer state type for the RAM8 bank.
// The bank can be built with the RAM8_BYPASS_EN macro; see ram8_bank.sv.
package ram_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int RAM8_DEPTH    = 8;
  localparam int RAM8_AW       = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/dmux8way.sv
// One-hot 8-way demultiplexer: routes in_i to out_o[sel_i], all other lanes 0.
// Lanes are formed as in_i AND (sel_i == k), so an unknown select with
// in_i low still yields all-zero enables.
module dmux8way (
  input  logic       in_i,
  input  logic [2:0] sel_i,
  output logic [7:0] out_o
);

  // Gate the input onto the selected lane only.
  always_comb begin
    out_o = '0;
    for (int k = 0; k < 8; k++) begin
      out_o[k] = in_i & (sel_i == 3'(k));
    end
  end

endmodule

// File: rtl/register_w.sv
// WIDTH-bit storage word with load enable and synchronous active-low reset.
module register_w #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Capture d_i on load; reset clears the word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ram8_bank.sv
// Eight-word register bank with a sequenced bulk-clear engine.
// Build option: define RAM8_BYPASS_EN for write-through forwarding of `in`
// onto `out` in the cycle a write is accepted.
//
//  state | meaning
//  IDLE  | normal operation; load writes word[address]; clr starts a sweep
//  CLEAR | one word zeroed per cycle at word[cnt]; load and clr ignored
import ram_pkg::*;

module ram8_bank #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in,
  input  logic [RAM8_AW-1:0] address,
  input  logic               load,
  input  logic               clr,
  output logic [WIDTH-1:0]   out,
  output logic               busy
);

  state_t               state_q;
  logic [RAM8_AW-1:0]   cnt_q;
  logic                 busy_q;

  logic                 clearing;
  logic                 wr_en;
  logic [RAM8_DEPTH-1:0] wr_sel;
  logic [RAM8_DEPTH-1:0] clr_sel;
  logic [WIDTH-1:0]     word_q [RAM8_DEPTH];
  logic [WIDTH-1:0]     rd_data;

  assign clearing = (state_q == CLEAR);

  // A clear request wins over a write issued in the same cycle.
  assign wr_en = load & ~clr & ~clearing;

  dmux8way u_wr_dmux (
    .in_i  (wr_en),
    .sel_i (address),
    .out_o (wr_sel)
  );

  dmux8way u_clr_dmux (
    .in_i  (clearing),
    .sel_i (cnt_q),
    .out_o (clr_sel)
  );

  // Clear sequencer: single sweep of 8 cycles; busy mirrors the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'(RAM8_DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Per-word 2:1 select: the sweep forces zero data and its own load strobe.
  for (genvar g = 0; g < RAM8_DEPTH; g++) begin : g_word
    logic [WIDTH-1:0] data_d;
    logic             load_d;

    assign data_d = clearing ? '0 : in;
    assign load_d = clearing ? clr_sel[g] : wr_sel[g];

    register_w #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (data_d),
      .load_i (load_d),
      .q_o    (word_q[g])
    );
  end

  assign rd_data = word_q[address];

`ifdef RAM8_BYPASS_EN
  // The write target is always word[address], so an accepted write forwards.
  assign out = wr_en ? in : rd_data;
`else
  assign out = rd_data;
`endif

  assign busy = busy_q;

endmodule
